// File: rtl/seg_scan6.sv
// Six-digit multiplexed seven-segment scanner with a frame-synchronous shadow
// register, leading-zero suppression and a blanking gap at the start of each slot.
module seg_scan6 #(
    parameter int SCAN_CYC  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] data_in,
    input  logic [5:0]  point,
    input  logic        blank_en,
    input  logic        data_vld,
    output logic        data_rdy,
    output logic [5:0]  sel,
    output logic [7:0]  seg
);

    localparam int CW = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic          pending_q, pending_d;
    logic [23:0]   shd_data_q, shd_data_d;
    logic [5:0]    shd_point_q, shd_point_d;
    logic          shd_blank_q, shd_blank_d;
    logic [23:0]   disp_data_q, disp_data_d;
    logic [5:0]    disp_point_q, disp_point_d;
    logic          disp_blank_q, disp_blank_d;
    logic [5:0]    sel_q, sel_d;
    logic [7:0]    seg_q, seg_d;

    logic       slot_end;
    logic       frame_end;
    logic       xfer;
    logic [5:0] upper_zero;
    logic [3:0] nib;
    logic       dp;
    logic       blank;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    assign slot_end  = (cnt_q == CW'(SCAN_CYC - 1));
    assign frame_end = slot_end && (idx_q == 3'd5);
    assign xfer      = data_vld && !pending_q;
    assign data_rdy  = !pending_q;
    assign sel       = sel_q;
    assign seg       = seg_q;

    // upper_zero[i]: digits i..5 carry neither a nonzero nibble nor a point.
    always_comb begin
        upper_zero[5] = (disp_data_q[23:20] == 4'h0) && !disp_point_q[5];
        for (int i = 4; i >= 0; i--) begin
            upper_zero[i] = upper_zero[i+1] && (disp_data_q[4*i +: 4] == 4'h0)
                            && !disp_point_q[i];
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned and infers a latch.
        cnt_d        = slot_end ? '0 : cnt_q + 1'b1;
        idx_d        = idx_q;
        pending_d    = pending_q;
        shd_data_d   = shd_data_q;
        shd_point_d  = shd_point_q;
        shd_blank_d  = shd_blank_q;
        disp_data_d  = disp_data_q;
        disp_point_d = disp_point_q;
        disp_blank_d = disp_blank_q;
        nib          = 4'h0;
        dp           = 1'b0;
        blank        = 1'b0;

        if (slot_end) begin
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end

        // A boundary load and a new capture are exclusive: capture needs pending clear.
        if (frame_end && pending_q) begin
            disp_data_d  = shd_data_q;
            disp_point_d = shd_point_q;
            disp_blank_d = shd_blank_q;
            pending_d    = 1'b0;
        end else if (xfer) begin
            shd_data_d  = data_in;
            shd_point_d = point;
            shd_blank_d = blank_en;
            pending_d   = 1'b1;
        end

        for (int i = 0; i < 6; i++) begin
            if (idx_q == 3'(i)) begin
                nib   = disp_data_q[4*i +: 4];
                dp    = disp_point_q[i];
                blank = (i != 0) && disp_blank_q && upper_zero[i];
            end
        end

        seg_d = blank ? 8'hFF : {~dp, hex7(nib)};
        sel_d = (cnt_q < CW'(BLANK_CYC)) ? 6'b000000 : (6'b000001 << idx_q);
    end

    // NOTE: state updates use non-blocking assignments so every register samples the pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q        <= '0;
            idx_q        <= 3'd0;
            pending_q    <= 1'b0;
            // NOTE: shadow and display contents are reset too, so a fresh start shows zeros instead of stale data.
            shd_data_q   <= 24'h0;
            shd_point_q  <= 6'h0;
            shd_blank_q  <= 1'b0;
            disp_data_q  <= 24'h0;
            disp_point_q <= 6'h0;
            disp_blank_q <= 1'b0;
            sel_q        <= 6'b000000;
            seg_q        <= 8'hFF;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            shd_data_q   <= shd_data_d;
            shd_point_q  <= shd_point_d;
            shd_blank_q  <= shd_blank_d;
            disp_data_q  <= disp_data_d;
            disp_point_q <= disp_point_d;
            disp_blank_q <= disp_blank_d;
            sel_q        <= sel_d;
            seg_q        <= seg_d;
        end
    end

endmodule
